// File: rtl/instmem_sync_if.sv
// Fetch/response/program-load bundle for instmem_sync. The master is the fetch
// unit or loader; the slave is the memory.
interface instmem_sync_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
);
  logic                   ra_valid;
  logic [INS_ADDRESS-1:0] ra;
  logic                   ra_ready;
  logic                   rd_valid;
  logic [INS_W-1:0]       rd;
  logic                   rd_fault;
  logic                   rd_ready;
  logic                   wr_en;
  logic [INS_ADDRESS-3:0] wa;
  logic [INS_W-1:0]       wd;
  logic                   init_busy;

  modport master (
    output ra_valid, ra, rd_ready, wr_en, wa, wd,
    input  ra_ready, rd_valid, rd, rd_fault, init_busy
  );

  modport slave (
    input  ra_valid, ra, rd_ready, wr_en, wa, wd,
    output ra_ready, rd_valid, rd, rd_fault, init_busy
  );
endinterface

// File: rtl/instmem_sync.sv
// Instruction memory: NOP-fills itself after reset, then serves word fetches.
// Fetch latency is 1 cycle; a single output register stalls ra_ready until rd_ready drains it.
module instmem_sync #(
  parameter int               INS_ADDRESS = 9,
  parameter int               INS_W       = 32,
  parameter logic [INS_W-1:0] NOP_INSN    = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  instmem_sync_if.slave bus
);

  localparam int AW    = INS_ADDRESS - 2;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST_IDX = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             rd_valid_q, rd_valid_d;
  logic [INS_W-1:0] rd_q, rd_d;
  logic             rd_fault_q, rd_fault_d;

  logic [INS_W-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [INS_W-1:0] mem_wd;

  logic             accept;
  logic             misaligned;
  logic [AW-1:0]    fetch_idx;

  assign fetch_idx  = bus.ra[INS_ADDRESS-1:2];
  assign misaligned = |bus.ra[1:0];

  // Gated by rst so nothing is ever reported as accepted on a reset edge.
  assign bus.ra_ready = !rst && (state_q == RUN) && (!rd_valid_q || bus.rd_ready);
  assign accept       = bus.ra_valid && bus.ra_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_d       = rd_q;
    rd_fault_d = rd_fault_q;
    mem_we     = 1'b0;
    mem_wa     = cnt_q;
    mem_wd     = NOP_INSN;

    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = NOP_INSN;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.wr_en) begin
          mem_we = 1'b1;
          mem_wa = bus.wa;
          mem_wd = bus.wd;
        end
        // mem_q is read before this edge's write lands: same-word fetch sees the old word.
        if (accept) begin
          rd_valid_d = 1'b1;
          rd_fault_d = misaligned;
          rd_d       = misaligned ? NOP_INSN : mem_q[fetch_idx];
        end else if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_q       <= NOP_INSN;
      rd_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_q       <= rd_d;
      rd_fault_q <= rd_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd        = rd_q;
  assign bus.rd_fault  = rd_fault_q;
  assign bus.init_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_instmem_sync.sv
// Scoreboard bench for instmem_sync: reference model predicts responses and handshake levels.
module tb_instmem_sync;
  localparam int          DEPTH = 128;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instmem_sync_if #(.INS_ADDRESS(9), .INS_W(32)) bus();

  instmem_sync #(.INS_ADDRESS(9), .INS_W(32), .NOP_INSN(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rd;
    logic        fault;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          clear_left  = 0;
  bit          model_valid = 1'b0;
  bit          armed       = 1'b0;
  int          n_chk       = 0;
  int          n_pass      = 0;
  logic [31:0] last_rd     = '0;
  logic        last_fault  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: per edge, mirrors the behaviour the memory must show.
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        armed       = 1'b1;
        clear_left  = DEPTH;
        model_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
      end else if (armed) begin
        if (clear_left > 0) begin
          clear_left--;
        end else begin
          if (bus.ra_valid && (!model_valid || bus.rd_ready)) begin
            e.fault = (bus.ra[1:0] != 2'b00);
            e.rd    = e.fault ? NOP : ref_mem[bus.ra[8:2]];
            exp_q.push_back(e);
            model_valid = 1'b1;
          end else if (bus.rd_ready) begin
            model_valid = 1'b0;
          end
          if (bus.wr_en) ref_mem[bus.wa] = bus.wd;
        end
      end
    end
  end

  // Monitor: compares handshake levels every cycle and response data while valid.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("ra_ready", 32'(bus.ra_ready),
              32'(!rst && clear_left == 0 && (!model_valid || bus.rd_ready)));
        check("init_busy", 32'(bus.init_busy), 32'(clear_left != 0));
        check("rd_valid", 32'(bus.rd_valid), 32'(model_valid));
        if (bus.rd_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected response");
          end else begin
            check("rd", bus.rd, exp_q[0].rd);
            check("rd_fault", 32'(bus.rd_fault), 32'(exp_q[0].fault));
            if (bus.rd_ready) begin
              last_rd    = bus.rd;
              last_fault = bus.rd_fault;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic count_busy(input string name, input int expected);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (!bus.init_busy) done = 1'b1;
      else n++;
    end
    if (!done) fail_now({name, " timeout"});
    else check(name, 32'(n), 32'(expected));
  endtask

  task automatic fetch(input logic [8:0] a, input bit keep);
    bit got = 1'b0;
    bus.ra_valid = 1'b1;
    bus.ra       = a;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.ra_ready) got = 1'b1;
    end
    cyc();
    if (!got) fail_now("fetch accept timeout");
    if (!keep || !got) bus.ra_valid = 1'b0;
  endtask

  task automatic load(input logic [6:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1;
    bus.wa    = a;
    bus.wd    = d;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic drain();
    bus.ra_valid = 1'b0;
    bus.rd_ready = 1'b1;
    repeat (3) cyc();
  endtask

  initial begin
    bus.ra_valid = 1'b0;
    bus.ra       = '0;
    bus.rd_ready = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wa       = '0;
    bus.wd       = '0;

    do_reset();
    count_busy("busy after reset", 128);
    check("reset rd", bus.rd, NOP);
    check("reset rd_fault", 32'(bus.rd_fault), 32'd0);
    cyc();

    fetch(9'h004, 1'b0);
    drain();
    check("cleared word", last_rd, NOP);
    check("cleared word fault", 32'(last_fault), 32'd0);

    load(7'd1, 32'h00100093);
    load(7'd2, 32'h00208433);
    fetch(9'h004, 1'b1);
    fetch(9'h008, 1'b0);
    drain();
    check("back-to-back second", last_rd, 32'h00208433);

    fetch(9'h006, 1'b0);
    drain();
    check("misaligned rd", last_rd, NOP);
    check("misaligned fault", 32'(last_fault), 32'd1);

    bus.rd_ready = 1'b0;
    fetch(9'h004, 1'b1);
    bus.ra = 9'h008;
    repeat (5) begin
      @(negedge clk);
      check("held rd", bus.rd, 32'h00100093);
      check("held ra_ready", 32'(bus.ra_ready), 32'd0);
    end
    cyc();
    bus.rd_ready = 1'b1;
    fetch(9'h008, 1'b0);
    drain();
    check("after stall", last_rd, 32'h00208433);

    bus.wr_en = 1'b1;
    bus.wa    = 7'd3;
    bus.wd    = 32'h404404b3;
    fetch(9'h00C, 1'b0);
    bus.wr_en = 1'b0;
    drain();
    check("read-before-write", last_rd, NOP);
    fetch(9'h00C, 1'b0);
    drain();
    check("write visible", last_rd, 32'h404404b3);

    repeat (600) begin
      bus.ra_valid = 1'($urandom_range(0, 1));
      bus.ra       = ($urandom_range(0, 3) == 0) ? 9'($urandom) : {7'($urandom), 2'b00};
      bus.rd_ready = ($urandom_range(0, 3) != 0);
      bus.wr_en    = ($urandom_range(0, 3) == 0);
      bus.wa       = 7'($urandom);
      bus.wd       = $urandom;
      cyc();
    end
    bus.wr_en = 1'b0;
    drain();

    do_reset();
    repeat (50) cyc();
    do_reset();
    count_busy("busy after mid-clear reset", 128);
    cyc();

    load(7'd1, 32'h00100093);
    load(7'd5, 32'hdeadbeef);
    bus.rd_ready = 1'b0;
    fetch(9'h014, 1'b0);
    cyc();
    do_reset();
    @(negedge clk);
    check("rd_valid dropped by reset", 32'(bus.rd_valid), 32'd0);
    check("busy right after reset", 32'(bus.init_busy), 32'd1);
    count_busy("busy after run reset", 127);
    bus.rd_ready = 1'b1;
    cyc();
    fetch(9'h014, 1'b0);
    drain();
    check("program discarded w5", last_rd, NOP);
    fetch(9'h004, 1'b0);
    drain();
    check("program discarded w1", last_rd, NOP);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
